// File: rtl/loader_pkg.sv
// Shared types and framing constants for the serial program loader.
// The CHK state only exists when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        WORD,
`ifdef LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERROR
    } loader_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/loader_word_packer.sv
// Packs accepted bytes big-endian into 32-bit words; pulses word_vld for one cycle after the 4th byte.
// Latency: 1 cycle from the 4th byte to word_vld. No backpressure: every byte_vld is taken.
module loader_word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic        last_byte,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_q, word_d;
    logic        word_vld_q, word_vld_d;

    assign last_byte = byte_vld && (byte_cnt_q == 2'(WORD_BYTES - 1));

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        word_vld_d = last_byte;
        if (byte_vld) begin
            word_d     = {word_q[23:0], byte_dat};
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
        end
    end

    assign word_vld = word_vld_q;
    assign word_dat = word_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed byte stream into instruction memory while holding the CPU in reset.
// Write strobe 1 cycle after each word's 4th byte; rx_ready_out stays high while loading (no stalls).
// Optional trailing XOR check byte when LOADER_CHECKSUM_EN is defined.
module program_loader
    import loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          MAX_WORDS = 256
) (
    input  logic        CLK_IN,
    input  logic        GLOBALRESET,
    input  logic        start_in,
    input  logic [7:0]  rx_data_in,
    input  logic        rx_valid_in,
    output logic        rx_ready_out,
    output logic [31:0] imem_addr_out,
    output logic [31:0] imem_data_out,
    output logic        imem_write_out,
    output logic        cpu_reset_out,
    output logic        done_out,
    output logic        error_out
);

    localparam logic [31:0] MAX_W = 32'(MAX_WORDS);
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t POST_LOAD = CHK;
`else
    localparam loader_state_t POST_LOAD = DONE;
`endif

    loader_state_t state_q, state_d;
    logic [7:0]    cnt_hi_q, cnt_hi_d;
    logic [15:0]   words_left_q, words_left_d;
    logic [15:0]   idx_q, idx_d;
    logic [31:0]   addr_q, addr_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]    chk_q, chk_d;
`endif

    logic          acc;
    logic          last_byte;
    logic [15:0]   hdr_count;

    always_comb begin
        rx_ready_out = (state_q == HDR_HI) || (state_q == HDR_LO) || (state_q == WORD)
`ifdef LOADER_CHECKSUM_EN
                    || (state_q == CHK)
`endif
                    ;
    end

    assign acc       = rx_valid_in && rx_ready_out;
    assign hdr_count = {cnt_hi_q, rx_data_in};

    loader_word_packer u_packer (
        .clk       (CLK_IN),
        .rst       (GLOBALRESET),
        .byte_vld  (acc && (state_q == WORD)),
        .byte_dat  (rx_data_in),
        .last_byte (last_byte),
        .word_vld  (imem_write_out),
        .word_dat  (imem_data_out)
    );

    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        words_left_d = words_left_q;
        idx_d        = idx_q;
        addr_d       = addr_q;
`ifdef LOADER_CHECKSUM_EN
        chk_d        = chk_q;
        if (acc && (state_q != CHK)) chk_d = chk_q ^ rx_data_in;
`endif
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_in) begin
                    state_d = HDR_HI;
                    idx_d   = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            HDR_HI: begin
                if (acc) begin
                    cnt_hi_d = rx_data_in;
                    state_d  = HDR_LO;
                end
            end
            HDR_LO: begin
                if (acc) begin
                    words_left_d = hdr_count;
                    if (hdr_count == 16'd0)          state_d = POST_LOAD;
                    else if ({16'h0, hdr_count} > MAX_W) state_d = ERROR;
                    else                             state_d = WORD;
                end
            end
            WORD: begin
                // Address is latched with the 4th byte so it lines up with the packer's strobe.
                if (last_byte) begin
                    addr_d       = BASE_ADDR + {14'b0, idx_q, 2'b00};
                    idx_d        = idx_q + 16'd1;
                    words_left_d = words_left_q - 16'd1;
                    if (words_left_q == 16'd1) state_d = POST_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
                if (acc) state_d = (rx_data_in == chk_q) ? DONE : ERROR;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (GLOBALRESET) begin
            state_q      <= IDLE;
            cnt_hi_q     <= '0;
            words_left_q <= '0;
            idx_q        <= '0;
            addr_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            words_left_q <= words_left_d;
            idx_q        <= idx_d;
            addr_q       <= addr_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q        <= chk_d;
`endif
        end
    end

    assign imem_addr_out = addr_q;
    assign cpu_reset_out = (state_q != DONE);
    assign done_out      = (state_q == DONE);
    assign error_out     = (state_q == ERROR);

endmodule
